can_bsp_gen: RTL and testbench
==============================

CAN_BSP_GEN -- requirements
Module: can_bsp_gen

Interface
REQ-001 Parameter WIDTH, default 8: bits per word; legal values 2..16.
REQ-002 Parameter PW, default $clog2(WIDTH): pointer width.
REQ-003 Parameter LSB_FIRST, default 0: 0 = MSB-first (pointer counts down), 1 = LSB-first (pointer counts up).
REQ-004 Port clk, input, 1: system clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high.
REQ-006 Port bit_en, input, 1: bit-time enable; one clk-wide pulse per CAN bit.
REQ-007 Port halt, input, 1: stuff bit; the current bit is not accepted.
REQ-008 Port tx_mode, input, 1: 1 = transmit, 0 = receive.
REQ-009 Port rx_bit, input, 1: received bus bit.
REQ-010 Port tx_word, input, WIDTH: word to serialise; upstream holds it stable for a whole word.
REQ-011 Port frame_start, input, 1: realign the pointer to the start of a new frame field.
REQ-012 Port rewind, input, 1: move the pointer backwards (direction change).
REQ-013 Port rewind_step, input, 2: rewind distance in bits, 0..3.
REQ-014 Port crc_en, input, 1: enable CRC accumulation.
REQ-015 Port tx_bit, output, 1: serial transmit bit.
REQ-016 Port rx_word, output, WIDTH: deserialised word.
REQ-017 Port ptr, output, PW: current bit position.
REQ-018 Port word_done, output, 1: one-cycle pulse when a word completes.
REQ-019 Port word_cnt, output, 4: completed words since frame_start; saturates at 15.
REQ-020 Port crc, output, 15: CAN CRC-15 register.

Function
REQ-021 START = WIDTH-1 when LSB_FIRST=0; START = 0 when LSB_FIRST=1.
REQ-022 LAST = 0 when LSB_FIRST=0; LAST = WIDTH-1 when LSB_FIRST=1.
REQ-023 tx_bit = tx_word[ptr], combinational, zero latency.
REQ-024 No state changes when bit_en=0.
REQ-025 When bit_en=1, priority is: frame_start > rewind > accept.
REQ-026 frame_start: ptr <= START; word_cnt <= 0; crc <= 0; rx_word is not written; halt is ignored.
REQ-027 rewind, when frame_start=0: ptr moves rewind_step positions opposite to the counting direction, modulo WIDTH.
REQ-028 rewind also applies when halt=1; it writes no data, leaves crc unchanged and never pulses word_done.
REQ-029 Accept = bit_en & !halt & !frame_start & !rewind.
REQ-030 Accept in receive mode: rx_word[ptr] <= rx_bit.
REQ-031 Accept in transmit mode: rx_word is unchanged.
REQ-032 Accept: bus bit b = tx_mode ? tx_bit : rx_bit.
REQ-033 Accept with crc_en=1: crc <= {crc[13:0],1'b0} ^ ((b ^ crc[14]) ? 15'h4599 : 0).
REQ-034 Accept with ptr != LAST: ptr steps one position in the counting direction.
REQ-035 Accept with ptr == LAST: ptr <= START; word_done=1 for exactly the next clk cycle; word_cnt increments, saturating at 15.
REQ-036 halt=1 with no rewind and no frame_start: ptr, rx_word, crc, word_cnt and word_done are all unchanged or inactive.
REQ-037 When WIDTH is not a power of two, pointer arithmetic wraps at WIDTH, never at 2^PW.

Reset
REQ-038 reset=1 immediately forces: ptr=START, rx_word=0, word_cnt=0, crc=0, word_done=0, regardless of clk.
REQ-039 A word in progress when reset asserts is discarded; the first accepted bit after release is written at START.

Verification (WIDTH=8 unless stated)
REQ-040 Receive, MSB-first: frame_start, then accept bits 1,0,1,1,0,0,1,0 -> rx_word=0xB2, one word_done pulse after the 8th bit, ptr=7, word_cnt=1.
REQ-041 Halt: halt=1 on bit_en between bits 3 and 4 of the REQ-040 sequence -> ptr, rx_word and crc unchanged for that bit; final rx_word=0xB2.
REQ-042 Transmit, LSB_FIRST=1, tx_word=0x35 -> tx_bit sequence 1,0,1,0,1,1,0,0; word_done after the 8th bit.
REQ-043 Rewind, MSB-first: ptr=1 with rewind_step=2 -> ptr=3; ptr=7 with rewind_step=1 -> ptr=0; with WIDTH=5, ptr=4 with rewind_step=1 -> ptr=0.
REQ-044 CRC: crc=0, accept bit 1 -> crc=0x4599; then accept bit 0 -> crc=0x4EAB; with crc_en=0 crc is unchanged.
REQ-045 Saturation and reset: 17 complete words -> word_cnt=15; reset asserted at ptr=3 between clk edges -> all outputs at reset values at once.

Source files
------------

// File: rtl/can_bsp_gen_if.sv
// Bundle of the CAN bit-stream processor signals between the frame controller and can_bsp_gen.
// master drives the per-bit controls; slave is the bit-stream processor itself.
interface can_bsp_gen_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PW    = $clog2(WIDTH)
);
   logic             bit_en;
   logic             halt;
   logic             tx_mode;
   logic             rx_bit;
   logic [WIDTH-1:0] tx_word;
   logic             frame_start;
   logic             rewind;
   logic [1:0]       rewind_step;
   logic             crc_en;
   logic             tx_bit;
   logic [WIDTH-1:0] rx_word;
   logic [PW-1:0]    ptr;
   logic             word_done;
   logic [3:0]       word_cnt;
   logic [14:0]      crc;

   modport master (
      output bit_en, halt, tx_mode, rx_bit, tx_word, frame_start, rewind, rewind_step, crc_en,
      input  tx_bit, rx_word, ptr, word_done, word_cnt, crc
   );

   modport slave (
      input  bit_en, halt, tx_mode, rx_bit, tx_word, frame_start, rewind, rewind_step, crc_en,
      output tx_bit, rx_word, ptr, word_done, word_cnt, crc
   );
endinterface

// File: rtl/can_bsp_gen.sv
// CAN bit-stream processor: serialises/deserialises WIDTH-bit words one bit per bit_en,
// tracks completed words and accumulates the CAN CRC-15 over the bus bits.
module can_bsp_gen #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned PW        = $clog2(WIDTH),
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   can_bsp_gen_if.slave bus
);
   localparam logic [PW-1:0] START = LSB_FIRST ? PW'(0) : PW'(WIDTH - 1);
   localparam logic [PW-1:0] LAST  = LSB_FIRST ? PW'(WIDTH - 1) : PW'(0);
   localparam int unsigned   XW    = PW + 2;
   localparam logic [XW-1:0] W1    = XW'(WIDTH);
   localparam logic [XW-1:0] W2    = XW'(2 * WIDTH);

   logic [PW-1:0]    r_ptr;
   logic [WIDTH-1:0] r_rx_word;
   logic [3:0]       r_word_cnt;
   logic [14:0]      r_crc;
   logic             r_word_done;

   logic             w_tx_bit;
   logic             w_accept;
   logic             w_last;
   logic             w_bus_bit;
   logic [14:0]      w_crc_step;
   logic [XW-1:0]    w_rw_raw;
   logic [XW-1:0]    w_rw_mod;
   logic [PW-1:0]    w_rw_ptr;
   logic [PW-1:0]    w_step_ptr;

   assign w_tx_bit   = bus.tx_word[r_ptr];
   assign w_accept   = bus.bit_en & ~bus.halt & ~bus.frame_start & ~bus.rewind;
   assign w_last     = (r_ptr == LAST);
   assign w_bus_bit  = bus.tx_mode ? w_tx_bit : bus.rx_bit;
   assign w_crc_step = {r_crc[13:0], 1'b0} ^ ((w_bus_bit ^ r_crc[14]) ? 15'h4599 : 15'h0000);

   // Rewind runs against the counting direction; the 2*WIDTH bias keeps the LSB-first case
   // non-negative, and the raw value is always below 3*WIDTH so two range checks suffice.
   always_comb begin
      if (LSB_FIRST) begin
         w_rw_raw = XW'(r_ptr) + W2 - XW'(bus.rewind_step);
      end else begin
         w_rw_raw = XW'(r_ptr) + XW'(bus.rewind_step);
      end
      if (w_rw_raw >= W2) begin
         w_rw_mod = w_rw_raw - W2;
      end else if (w_rw_raw >= W1) begin
         w_rw_mod = w_rw_raw - W1;
      end else begin
         w_rw_mod = w_rw_raw;
      end
      w_rw_ptr = w_rw_mod[PW-1:0];
   end

   always_comb begin
      if (LSB_FIRST) begin
         w_step_ptr = r_ptr + PW'(1);
      end else begin
         w_step_ptr = r_ptr - PW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr       <= START;
         r_rx_word   <= '0;
         r_word_cnt  <= 4'd0;
         r_crc       <= 15'h0000;
         r_word_done <= 1'b0;
      end else begin
         r_word_done <= 1'b0;
         if (bus.bit_en && bus.frame_start) begin
            r_ptr      <= START;
            r_word_cnt <= 4'd0;
            r_crc      <= 15'h0000;
         end else if (bus.bit_en && bus.rewind) begin
            r_ptr <= w_rw_ptr;
         end else if (w_accept) begin
            if (!bus.tx_mode) begin
               r_rx_word[r_ptr] <= bus.rx_bit;
            end
            if (bus.crc_en) begin
               r_crc <= w_crc_step;
            end
            if (w_last) begin
               r_ptr       <= START;
               r_word_done <= 1'b1;
               if (r_word_cnt != 4'hF) begin
                  r_word_cnt <= r_word_cnt + 4'd1;
               end
            end else begin
               r_ptr <= w_step_ptr;
            end
         end
      end
   end

   assign bus.tx_bit    = w_tx_bit;
   assign bus.rx_word   = r_rx_word;
   assign bus.ptr       = r_ptr;
   assign bus.word_done = r_word_done;
   assign bus.word_cnt  = r_word_cnt;
   assign bus.crc       = r_crc;
endmodule

// File: tb/tb_can_bsp_gen.sv
// Bench for can_bsp_gen: three instances (8-bit MSB-first, 8-bit LSB-first, 5-bit MSB-first)
// share stimulus; completed words are scoreboarded, register state is checked directly.
module tb_can_bsp_gen;
   logic       clk;
   logic       reset;
   logic [2:0] sel;
   logic       bit_en, halt, tx_mode, rx_bit, frame_start, rewind, crc_en;
   logic [1:0] rewind_step;
   logic [7:0] tx_word;

   int n_cmp;
   int n_err;

   logic [11:0] q_m[$];
   logic [11:0] q_l[$];
   logic [11:0] q_5[$];

   can_bsp_gen_if #(.WIDTH(8)) if_m ();
   can_bsp_gen_if #(.WIDTH(8)) if_l ();
   can_bsp_gen_if #(.WIDTH(5)) if_5 ();

   assign if_m.bit_en      = bit_en & sel[0];
   assign if_m.halt        = halt;
   assign if_m.tx_mode     = tx_mode;
   assign if_m.rx_bit      = rx_bit;
   assign if_m.tx_word     = tx_word;
   assign if_m.frame_start = frame_start;
   assign if_m.rewind      = rewind;
   assign if_m.rewind_step = rewind_step;
   assign if_m.crc_en      = crc_en;

   assign if_l.bit_en      = bit_en & sel[1];
   assign if_l.halt        = halt;
   assign if_l.tx_mode     = tx_mode;
   assign if_l.rx_bit      = rx_bit;
   assign if_l.tx_word     = tx_word;
   assign if_l.frame_start = frame_start;
   assign if_l.rewind      = rewind;
   assign if_l.rewind_step = rewind_step;
   assign if_l.crc_en      = crc_en;

   assign if_5.bit_en      = bit_en & sel[2];
   assign if_5.halt        = halt;
   assign if_5.tx_mode     = tx_mode;
   assign if_5.rx_bit      = rx_bit;
   assign if_5.tx_word     = tx_word[4:0];
   assign if_5.frame_start = frame_start;
   assign if_5.rewind      = rewind;
   assign if_5.rewind_step = rewind_step;
   assign if_5.crc_en      = crc_en;

   can_bsp_gen #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .reset(reset), .bus(if_m));
   can_bsp_gen #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .reset(reset), .bus(if_l));
   can_bsp_gen #(.WIDTH(5), .LSB_FIRST(1'b0)) u_w5  (.clk(clk), .reset(reset), .bus(if_5));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected $finish before it");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic mon_pop(input string name, input logic [11:0] act, input int qsize,
                          input logic [11:0] exp);
      n_cmp++;
      if (qsize == 0) begin
         n_err++;
         $display("FAIL %s: word_done with {cnt,word}=0x%0h, expected no pulse", name, act);
      end else if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {cnt,word}=0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops one expected {word_cnt, rx_word} per word_done pulse.
   task automatic mon_loop();
      logic [11:0] e;
      forever begin
         @(negedge clk);
         if (if_m.word_done) begin
            e = (q_m.size() > 0) ? q_m[0] : 12'h000;
            mon_pop("msb_word", {if_m.word_cnt, if_m.rx_word}, q_m.size(), e);
            if (q_m.size() > 0) void'(q_m.pop_front());
         end
         if (if_l.word_done) begin
            e = (q_l.size() > 0) ? q_l[0] : 12'h000;
            mon_pop("lsb_word", {if_l.word_cnt, if_l.rx_word}, q_l.size(), e);
            if (q_l.size() > 0) void'(q_l.pop_front());
         end
         if (if_5.word_done) begin
            e = (q_5.size() > 0) ? q_5[0] : 12'h000;
            mon_pop("w5_word", {if_5.word_cnt, 3'b000, if_5.rx_word}, q_5.size(), e);
            if (q_5.size() > 0) void'(q_5.pop_front());
         end
      end
   endtask

   task automatic step(input logic h, input logic fs, input logic rw, input logic [1:0] rs,
                       input logic rb);
      @(negedge clk);
      bit_en = 1'b1; halt = h; frame_start = fs; rewind = rw; rewind_step = rs; rx_bit = rb;
      @(posedge clk);
      #1;
      bit_en = 1'b0; halt = 1'b0; frame_start = 1'b0; rewind = 1'b0; rewind_step = 2'd0;
   endtask

   task automatic acc(input logic rb);
      step(1'b0, 1'b0, 1'b0, 2'd0, rb);
   endtask

   task automatic fstart();
      step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
   endtask

   logic exp_tx [8];

   initial begin
      n_cmp = 0; n_err = 0;
      reset = 1'b1; sel = 3'b000; bit_en = 1'b0; halt = 1'b0; tx_mode = 1'b0; rx_bit = 1'b0;
      frame_start = 1'b0; rewind = 1'b0; rewind_step = 2'd0; crc_en = 1'b0; tx_word = 8'h00;
      exp_tx = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      fork
         mon_loop();
      join_none
      #12 reset = 1'b0;
      #2;
      chk("reset_msb_ptr", 32'(if_m.ptr), 32'd7);
      chk("reset_lsb_ptr", 32'(if_l.ptr), 32'd0);
      chk("reset_w5_ptr", 32'(if_5.ptr), 32'd4);
      chk("reset_rx_word", 32'(if_m.rx_word), 32'h00);
      chk("reset_word_cnt", 32'(if_m.word_cnt), 32'd0);
      chk("reset_crc", 32'(if_m.crc), 32'h0000);
      chk("reset_word_done", 32'(if_m.word_done), 32'd0);

      // Receive MSB-first with a halted bit, CRC over the first three bits.
      sel = 3'b001; tx_mode = 1'b0; crc_en = 1'b1;
      fstart();
      chk("fs_ptr", 32'(if_m.ptr), 32'd7);
      acc(1'b1);
      chk("crc_bit1", 32'(if_m.crc), 32'h4599);
      chk("rx_ptr_after1", 32'(if_m.ptr), 32'd6);
      acc(1'b0);
      chk("crc_bit0", 32'(if_m.crc), 32'h4EAB);
      acc(1'b1);
      chk("crc_bit3", 32'(if_m.crc), 32'h1D56);
      chk("rx_partial", 32'(if_m.rx_word), 32'hA0);
      step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
      chk("halt_ptr", 32'(if_m.ptr), 32'd4);
      chk("halt_rx_word", 32'(if_m.rx_word), 32'hA0);
      chk("halt_crc", 32'(if_m.crc), 32'h1D56);
      chk("halt_word_done", 32'(if_m.word_done), 32'd0);
      crc_en = 1'b0;
      acc(1'b1); acc(1'b0); acc(1'b0); acc(1'b1);
      q_m.push_back({4'd1, 8'hB2});
      acc(1'b0);
      chk("rx_word_final", 32'(if_m.rx_word), 32'hB2);
      chk("rx_ptr_final", 32'(if_m.ptr), 32'd7);
      chk("rx_word_cnt", 32'(if_m.word_cnt), 32'd1);
      chk("crc_en0_hold", 32'(if_m.crc), 32'h1D56);

      // Rewind, MSB-first.
      step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
      chk("rewind_7_by1", 32'(if_m.ptr), 32'd0);
      chk("rewind_no_done", 32'(if_m.word_done), 32'd0);
      fstart();
      for (int i = 0; i < 6; i++) acc(1'b0);
      chk("ptr_before_rw2", 32'(if_m.ptr), 32'd1);
      step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
      chk("rewind_1_by2", 32'(if_m.ptr), 32'd3);
      step(1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
      chk("rewind_halted", 32'(if_m.ptr), 32'd4);

      // WIDTH=5: wrap at 5, not at 8.
      sel = 3'b100;
      chk("w5_ptr_idle", 32'(if_5.ptr), 32'd4);
      step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
      chk("w5_rewind_4_by1", 32'(if_5.ptr), 32'd0);
      fstart();
      chk("w5_fs_ptr", 32'(if_5.ptr), 32'd4);
      q_5.push_back({4'd1, 8'h1F});
      for (int i = 0; i < 5; i++) begin
         acc(1'b1);
         chk("w5_step_ptr", 32'(if_5.ptr), (i == 4) ? 32'd4 : 32'(3 - i));
      end

      // Transmit, LSB-first, tx_word=0x35.
      sel = 3'b010; tx_mode = 1'b1; tx_word = 8'h35;
      fstart();
      chk("lsb_fs_ptr", 32'(if_l.ptr), 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("lsb_tx_bit", 32'(if_l.tx_bit), 32'(exp_tx[i]));
         if (i == 7) q_l.push_back({4'd1, 8'h00});
         acc(1'b0);
      end
      chk("lsb_ptr_wrap", 32'(if_l.ptr), 32'd0);
      chk("lsb_word_cnt", 32'(if_l.word_cnt), 32'd1);

      // Saturation: 17 words, alternating all-zero / all-one content.
      sel = 3'b001; tx_mode = 1'b0;
      fstart();
      for (int w = 0; w < 17; w++) begin
         q_m.push_back({(w >= 14) ? 4'd15 : 4'(w + 1), (w % 2 == 1) ? 8'hFF : 8'h00});
         for (int b = 0; b < 8; b++) acc(w % 2 == 1);
      end
      chk("sat_word_cnt", 32'(if_m.word_cnt), 32'd15);

      // Reset in the middle of a word.
      crc_en = 1'b1;
      for (int i = 0; i < 4; i++) acc(1'b1);
      chk("pre_reset_ptr", 32'(if_m.ptr), 32'd3);
      chk("pre_reset_crc", 32'(if_m.crc), 32'h27FA);
      chk("pre_reset_rx", 32'(if_m.rx_word), 32'hF0);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_ptr", 32'(if_m.ptr), 32'd7);
      chk("async_rst_rx", 32'(if_m.rx_word), 32'h00);
      chk("async_rst_cnt", 32'(if_m.word_cnt), 32'd0);
      chk("async_rst_crc", 32'(if_m.crc), 32'h0000);
      chk("async_rst_done", 32'(if_m.word_done), 32'd0);
      #3 reset = 1'b0;
      acc(1'b1);
      chk("post_rst_rx", 32'(if_m.rx_word), 32'h80);
      chk("post_rst_ptr", 32'(if_m.ptr), 32'd6);

      repeat (3) @(posedge clk);
      #1;
      chk("msb_words_left", 32'(q_m.size()), 32'd0);
      chk("lsb_words_left", 32'(q_l.size()), 32'd0);
      chk("w5_words_left", 32'(q_5.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
